run_scan_checker: RTL and testbench
===================================

RUN_SCAN_CHECKER -- requirements
Module: run_scan_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, width of the data-memory debug address.
REQ-002 SHALL have parameter NOP_LIMIT, default 8, consecutive-NOP count that ends a run.
REQ-003 SHALL have parameter LOOP_LIMIT, default 50, repeated-instruction count that ends a run.
REQ-004 SHALL have port CLK, input, 1, clock.
REQ-005 SHALL have port nrst, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port if_inst, input, 32, instruction currently fetched by the core.
REQ-007 SHALL have port max_addr, input, ADDR_W, last word address to check (inclusive).
REQ-008 SHALL have port con_addr, output, ADDR_W, core debug-port read address.
REQ-009 SHALL have port con_out, input, 32, core debug-port read data, valid one cycle after con_addr.
REQ-010 SHALL have port ref_addr, output, ADDR_W, answer-key ROM address.
REQ-011 SHALL have port ref_data, input, 32, answer-key ROM data, valid one cycle after ref_addr.
REQ-012 SHALL have port done, output, 1, high from the run-end cycle until reset.
REQ-013 SHALL have port end_reason, output, 1, 0 = NOP streak, 1 = repeated-instruction loop.
REQ-014 SHALL have port fail_valid, output, 1, one-cycle pulse per mismatching word.
REQ-015 SHALL have port fail_addr / fail_actual / fail_expected, outputs, ADDR_W/32/32, mismatch details, held until the next fail_valid.
REQ-016 SHALL have port report_valid, output, 1, high once all compares are complete, until reset.
REQ-017 SHALL have port pass_count and total_count, outputs, ADDR_W+1 each, matched words and compared words.
REQ-018 SHALL have port cycle_count, output, 32, run cycles excluding the terminating streak.

Function
REQ-019 SHALL treat an instruction as a NOP when if_inst[15:0]==16'h0001 or if_inst==32'h00000013.
REQ-020 SHALL keep a last_inst register; it updates to if_inst only on cycles that clear the streaks.
REQ-021 In RUN, when both last_inst and if_inst are NOPs, SHALL increment nop_streak and loop_streak.
REQ-022 In RUN, otherwise when if_inst==last_inst, SHALL increment loop_streak only.
REQ-023 In RUN, otherwise SHALL load last_inst, clear nop_streak and loop_streak.
REQ-024 SHALL use the FSM RUN -> SCAN -> DRAIN -> REPORT; REPORT is terminal until reset.
REQ-025 RUN->SCAN SHALL occur on the cycle after nop_streak==NOP_LIMIT or loop_streak==LOOP_LIMIT; if both hold, end_reason=0.
REQ-026 cycle_count SHALL increment every RUN cycle and, at the transition, be reduced by NOP_LIMIT (reason 0) or LOOP_LIMIT (reason 1), saturating at 0.
REQ-027 In SCAN, SHALL drive con_addr=ref_addr, starting at 0 and incrementing by 1 per cycle up to max_addr, with no wrap.
REQ-028 SCAN->DRAIN SHALL occur after issuing max_addr; DRAIN SHALL last one cycle for the final compare.
REQ-029 Each compare SHALL occur one cycle after its address issue: total_count+1; pass_count+1 on equality; otherwise fail_valid pulses with a registered address and data.
REQ-030 max_addr=0 SHALL give exactly one compare; max_addr=2^ADDR_W-1 SHALL give total_count=2^ADDR_W with no address wrap.
REQ-031 report_valid SHALL rise on the cycle after the DRAIN compare; counts SHALL be final at that point.
REQ-032 Changes on if_inst after leaving RUN SHALL be ignored.

Reset
REQ-033 On nrst low at a CLK edge, in any state including mid-SCAN, SHALL enter RUN and zero every output, counter, streak and last_inst.

Structure
REQ-034 The FSM state enum, NOP encodings and end_reason codes SHALL live in the shared core package.
REQ-035 Streak detection SHALL be one sub-module, run_end_detect, that outputs end_hit and end_reason.

Verification
REQ-036 Send 20 distinct instructions, then 32'h13 repeatedly -> done after 8 NOP-pair cycles, end_reason=0, cycle_count=run cycles-8.
REQ-037 Hold if_inst=32'h0000006F (self-jump) -> end_reason=1 when loop_streak=50.
REQ-038 max_addr=3, memory==ROM except word 2 (actual 0xDEADBEEF, expected 0x0) -> one fail_valid, fail_addr=2, pass_count=3, total_count=4.
REQ-039 max_addr=0, matching -> total_count=1, pass_count=1, report_valid 2 cycles after SCAN entry.
REQ-040 Assert nrst low during SCAN at address 5 -> next cycle: RUN, all outputs 0; a rerun gives identical results.
REQ-041 Mixed C.NOP 16'h0001 and 32'h13 stream -> both count as NOPs; done after 8 pairs.

Source files
------------

// File: rtl/run_scan_checker_pkg.sv
// Shared definitions for the run/scan result checker: FSM states, NOP encodings,
// end-reason codes and the compare payload.
package run_scan_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam logic [15:0] CNOP_ENC = 16'h0001;
  localparam logic [31:0] NOP_ENC  = 32'h0000_0013;

  localparam logic END_NOP  = 1'b0;
  localparam logic END_LOOP = 1'b1;

  typedef struct packed {
    logic [31:0] actual;
    logic [31:0] expected;
  } cmp_word_t;

  // Compressed C.NOP (low half) or canonical addi x0,x0,0.
  function automatic logic is_nop(input logic [31:0] inst);
    return (inst[15:0] == CNOP_ENC) || (inst == NOP_ENC);
  endfunction

endpackage

// File: rtl/run_scan_checker_end_detect.sv
// run_end_detect: tracks NOP and repeated-instruction streaks while the core runs
// and flags the cycle in which either streak has reached its limit.
module run_end_detect
  import run_scan_checker_pkg::*;
#(
  parameter int unsigned NOP_LIMIT  = 8,
  parameter int unsigned LOOP_LIMIT = 50
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        run_i,
  input  logic [31:0] inst_i,
  output logic        end_hit_o,
  output logic        end_reason_o
);

  localparam int unsigned NOP_W  = $clog2(NOP_LIMIT + 1);
  localparam int unsigned LOOP_W = $clog2(LOOP_LIMIT + 1);

  logic [31:0]       last_q, last_d;
  logic [NOP_W-1:0]  nop_q, nop_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic              end_hit_q, end_hit_d;
  logic              end_reason_q, end_reason_d;
  logic              nop_hit, loop_hit;

  // Streak update; counters saturate so they never wrap before the FSM reacts.
  always_comb begin
    last_d       = last_q;
    nop_d        = nop_q;
    loop_d       = loop_q;
    nop_hit      = 1'b0;
    loop_hit     = 1'b0;
    end_hit_d    = end_hit_q;
    end_reason_d = end_reason_q;
    if (run_i) begin
      if (is_nop(last_q) && is_nop(inst_i)) begin
        if (nop_q != NOP_W'(NOP_LIMIT))   nop_d  = nop_q + NOP_W'(1);
        if (loop_q != LOOP_W'(LOOP_LIMIT)) loop_d = loop_q + LOOP_W'(1);
      end else if (inst_i == last_q) begin
        if (loop_q != LOOP_W'(LOOP_LIMIT)) loop_d = loop_q + LOOP_W'(1);
      end else begin
        last_d = inst_i;
        nop_d  = '0;
        loop_d = '0;
      end
      nop_hit      = (nop_d == NOP_W'(NOP_LIMIT));
      loop_hit     = (loop_d == LOOP_W'(LOOP_LIMIT));
      end_hit_d    = nop_hit || loop_hit;
      end_reason_d = nop_hit ? END_NOP : END_LOOP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      last_q       <= '0;
      nop_q        <= '0;
      loop_q       <= '0;
      end_hit_q    <= 1'b0;
      end_reason_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      nop_q        <= nop_d;
      loop_q       <= loop_d;
      end_hit_q    <= end_hit_d;
      end_reason_q <= end_reason_d;
    end
  end

  assign end_hit_o    = end_hit_q;
  assign end_reason_o = end_reason_q;

endmodule

// File: rtl/run_scan_checker.sv
// Watches the core until its program ends (NOP streak or tight loop), then scans
// data memory against the answer-key ROM and reports per-word mismatches and totals.
module run_scan_checker
  import run_scan_checker_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned NOP_LIMIT  = 8,
  parameter int unsigned LOOP_LIMIT = 50
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic [31:0]       if_inst,
  input  logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W-1:0] con_addr,
  input  logic [31:0]       con_out,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic [31:0]       ref_data,
  output logic              done,
  output logic              end_reason,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [31:0]       fail_actual,
  output logic [31:0]       fail_expected,
  output logic              report_valid,
  output logic [ADDR_W:0]   pass_count,
  output logic [ADDR_W:0]   total_count,
  output logic [31:0]       cycle_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              done_q, done_d;
  logic              reason_q, reason_d;
  logic              fail_valid_q, fail_valid_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  cmp_word_t         fail_word_q, fail_word_d;
  logic              report_q, report_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       cycle_inc, end_limit;
  logic              end_hit, end_code;

  run_end_detect #(
    .NOP_LIMIT (NOP_LIMIT),
    .LOOP_LIMIT(LOOP_LIMIT)
  ) u_end_detect (
    .CLK         (CLK),
    .nrst        (nrst),
    .run_i       (state_q == ST_RUN),
    .inst_i      (if_inst),
    .end_hit_o   (end_hit),
    .end_reason_o(end_code)
  );

  // Next-state and datapath; compare stage trails address issue by one cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmp_valid_d  = 1'b0;
    cmp_addr_d   = addr_q;
    done_d       = done_q;
    reason_d     = reason_q;
    fail_valid_d = 1'b0;
    fail_addr_d  = fail_addr_q;
    fail_word_d  = fail_word_q;
    report_d     = report_q;
    pass_d       = pass_q;
    total_d      = total_q;
    cycle_d      = cycle_q;
    cycle_inc    = cycle_q + 32'd1;
    end_limit    = (end_code == END_NOP) ? 32'(NOP_LIMIT) : 32'(LOOP_LIMIT);

    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_inc;
        if (end_hit) begin
          state_d  = ST_SCAN;
          done_d   = 1'b1;
          reason_d = end_code;
          addr_d   = '0;
          // Terminating streak is not part of the program's run time.
          cycle_d  = (cycle_inc > end_limit) ? (cycle_inc - end_limit) : 32'd0;
        end
      end
      ST_SCAN: begin
        cmp_valid_d = 1'b1;
        if (addr_q == max_addr) state_d = ST_DRAIN;
        else                    addr_d  = addr_q + ADDR_W'(1);
      end
      ST_DRAIN: begin
        state_d  = ST_REPORT;
        report_d = 1'b1;
      end
      ST_REPORT: begin
        state_d = ST_REPORT;
      end
      default: state_d = ST_RUN;
    endcase

    if (cmp_valid_q) begin
      total_d = total_q + CNT_W'(1);
      if (con_out == ref_data) begin
        pass_d = pass_q + CNT_W'(1);
      end else begin
        fail_valid_d         = 1'b1;
        fail_addr_d          = cmp_addr_q;
        fail_word_d.actual   = con_out;
        fail_word_d.expected = ref_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q      <= ST_RUN;
      addr_q       <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      done_q       <= 1'b0;
      reason_q     <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_word_q  <= '0;
      report_q     <= 1'b0;
      pass_q       <= '0;
      total_q      <= '0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      done_q       <= done_d;
      reason_q     <= reason_d;
      fail_valid_q <= fail_valid_d;
      fail_addr_q  <= fail_addr_d;
      fail_word_q  <= fail_word_d;
      report_q     <= report_d;
      pass_q       <= pass_d;
      total_q      <= total_d;
      cycle_q      <= cycle_d;
    end
  end

  assign con_addr      = addr_q;
  assign ref_addr      = addr_q;
  assign done          = done_q;
  assign end_reason    = reason_q;
  assign fail_valid    = fail_valid_q;
  assign fail_addr     = fail_addr_q;
  assign fail_actual   = fail_word_q.actual;
  assign fail_expected = fail_word_q.expected;
  assign report_valid  = report_q;
  assign pass_count    = pass_q;
  assign total_count   = total_q;
  assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_run_scan_checker.sv
// Bench for run_scan_checker: directed end-of-run/scan scenarios plus randomized
// instruction streams and memory contents checked against a behavioural model.
module tb_run_scan_checker;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned NOP_LIMIT  = 8;
  localparam int unsigned LOOP_LIMIT = 50;
  localparam int          DEPTH      = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              nrst = 1'b0;
  logic [31:0]       if_inst = '0;
  logic [ADDR_W-1:0] max_addr = '0;
  logic [ADDR_W-1:0] con_addr, ref_addr;
  logic [31:0]       con_out = '0, ref_data = '0;
  logic              done, end_reason, fail_valid, report_valid;
  logic [ADDR_W-1:0] fail_addr;
  logic [31:0]       fail_actual, fail_expected, cycle_count;
  logic [ADDR_W:0]   pass_count, total_count;

  logic [31:0] mem [DEPTH];
  logic [31:0] rom [DEPTH];

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_last;
  int          m_nop, m_loop, m_runs, m_cc;
  bit          m_done, m_reason;
  int          m_done_at, obs_done_at, lat;
  logic [ADDR_W-1:0] fa_q[$];
  logic [31:0]       fx_q[$], fe_q[$];

  run_scan_checker #(.ADDR_W(ADDR_W), .NOP_LIMIT(NOP_LIMIT), .LOOP_LIMIT(LOOP_LIMIT)) dut (
    .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .max_addr(max_addr),
    .con_addr(con_addr), .con_out(con_out), .ref_addr(ref_addr), .ref_data(ref_data),
    .done(done), .end_reason(end_reason), .fail_valid(fail_valid), .fail_addr(fail_addr),
    .fail_actual(fail_actual), .fail_expected(fail_expected), .report_valid(report_valid),
    .pass_count(pass_count), .total_count(total_count), .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge CLK) begin
    con_out  <= mem[con_addr];
    ref_data <= rom[ref_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit ref_is_nop(input logic [31:0] x);
    return (x[15:0] == 16'h0001) || (x == 32'h0000_0013);
  endfunction

  task automatic model_clear();
    m_last = '0; m_nop = 0; m_loop = 0; m_runs = 0; m_cc = 0; m_done = 0; m_reason = 0;
  endtask

  // One RUN cycle of the program-end rules.
  task automatic model_step(input logic [31:0] inst);
    int lim;
    if (m_done) return;
    m_runs++;
    if (m_nop == NOP_LIMIT || m_loop == LOOP_LIMIT) begin
      m_done   = 1;
      m_reason = (m_nop == NOP_LIMIT) ? 1'b0 : 1'b1;
      lim      = m_reason ? LOOP_LIMIT : NOP_LIMIT;
      m_cc     = (m_runs > lim) ? m_runs - lim : 0;
    end else if (ref_is_nop(m_last) && ref_is_nop(inst)) begin
      m_nop++; m_loop++;
    end else if (inst == m_last) begin
      m_loop++;
    end else begin
      m_last = inst; m_nop = 0; m_loop = 0;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    if_inst = '0;
    repeat (2) @(posedge CLK);
    #1;
    nrst = 1'b1;
    model_clear();
  endtask

  task automatic fill();
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = $urandom();
      mem[a] = rom[a];
    end
  endtask

  // Drive an instruction stream until the model or the DUT ends the run.
  task automatic feed(input int mode, input int bound);
    logic [31:0] inst, tmp, prev;
    int r;
    obs_done_at = -1; m_done_at = -1; prev = 32'h0000_0093;
    for (int i = 0; i < bound; i++) begin
      tmp = $urandom();
      case (mode)
        0: inst = (i < 20) ? (32'h0010_0093 + (32'(i) << 20)) : 32'h0000_0013;
        1: inst = 32'h0000_006F;
        2: inst = (i < 5) ? (32'h0010_0093 + (32'(i) << 20))
                          : ((tmp[0]) ? 32'h0000_0013 : {tmp[31:16], 16'h0001});
        default: begin
          r = $urandom_range(0, 9);
          if (i >= 300)   inst = 32'h0000_0013;
          else if (r < 3) inst = 32'h0000_0013;
          else if (r == 3) inst = {tmp[31:16], 16'h0001};
          else if (r < 6) inst = 32'h0000_006F;
          else if (r == 6) inst = prev;
          else             inst = {tmp[31:2], 2'b11};
        end
      endcase
      prev = inst;
      if_inst = inst;
      @(posedge CLK);
      model_step(inst);
      #1;
      if (m_done && m_done_at < 0) m_done_at = i;
      if (done && obs_done_at < 0) obs_done_at = i;
      if (m_done || obs_done_at >= 0) break;
    end
    if_inst = $urandom();
  endtask

  // Follow the scan until report_valid, recording every fail pulse.
  task automatic collect(input int bound);
    lat = -1;
    fa_q.delete(); fx_q.delete(); fe_q.delete();
    for (int i = 1; i <= bound; i++) begin
      if_inst = $urandom();
      @(posedge CLK);
      #1;
      if (fail_valid) begin
        fa_q.push_back(fail_addr); fx_q.push_back(fail_actual); fe_q.push_back(fail_expected);
      end
      if (report_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    total++; if (done !== 1'b0 || report_valid !== 1'b0 || fail_valid !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got done=%b rep=%b fv=%b want 0", done, report_valid, fail_valid); end
    total++; if (con_addr !== '0 || ref_addr !== '0) begin
      bad++; $display("FAIL reset_addr: got %0h/%0h want 0", con_addr, ref_addr); end
    total++; if (pass_count !== '0 || total_count !== '0 || cycle_count !== '0) begin
      bad++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0", pass_count, total_count, cycle_count); end
    total++; if (fail_addr !== '0 || fail_actual !== '0 || fail_expected !== '0 || end_reason !== 1'b0) begin
      bad++; $display("FAIL reset_fail_regs: got %0h %0h %0h %b want 0", fail_addr, fail_actual, fail_expected, end_reason); end
  endtask

  task automatic test_nop_end();
    max_addr = 11'd3;
    fill();
    mem[2] = 32'hDEAD_BEEF; rom[2] = 32'h0;
    do_reset();
    feed(0, 200);
    total++; if (obs_done_at !== 29) begin bad++; $display("FAIL nop_done_time: got %0d want 29", obs_done_at); end
    total++; if (end_reason !== 1'b0) begin bad++; $display("FAIL nop_reason: got %b want 0", end_reason); end
    total++; if (cycle_count !== 32'd22) begin bad++; $display("FAIL nop_cycles: got %0d want 22", cycle_count); end
    collect(30);
    total++; if (lat !== 5) begin bad++; $display("FAIL nop_report_lat: got %0d want 5", lat); end
    total++; if (fa_q.size() !== 1) begin bad++; $display("FAIL nop_fail_cnt: got %0d want 1", fa_q.size()); end
    else begin
      total++; if (fa_q[0] !== 11'd2 || fx_q[0] !== 32'hDEAD_BEEF || fe_q[0] !== 32'h0) begin
        bad++; $display("FAIL nop_fail_data: got %0h %0h %0h want 2 deadbeef 0", fa_q[0], fx_q[0], fe_q[0]); end
    end
    total++; if (pass_count !== 12'd3 || total_count !== 12'd4) begin
      bad++; $display("FAIL nop_counts: got %0d/%0d want 3/4", pass_count, total_count); end
    @(posedge CLK); #1;
    total++; if (report_valid !== 1'b1 || done !== 1'b1 || fail_valid !== 1'b0 || fail_addr !== 11'd2) begin
      bad++; $display("FAIL nop_hold: got rep=%b done=%b fv=%b fa=%0h want 1 1 0 2", report_valid, done, fail_valid, fail_addr); end
  endtask

  task automatic test_loop_end();
    max_addr = 11'd0;
    fill();
    do_reset();
    feed(1, 200);
    total++; if (obs_done_at !== 51) begin bad++; $display("FAIL loop_done_time: got %0d want 51", obs_done_at); end
    total++; if (end_reason !== 1'b1) begin bad++; $display("FAIL loop_reason: got %b want 1", end_reason); end
    total++; if (cycle_count !== 32'd2) begin bad++; $display("FAIL loop_cycles: got %0d want 2", cycle_count); end
    collect(20);
    total++; if (lat !== 2) begin bad++; $display("FAIL max0_report_lat: got %0d want 2", lat); end
    total++; if (pass_count !== 12'd1 || total_count !== 12'd1 || fa_q.size() !== 0) begin
      bad++; $display("FAIL max0_counts: got %0d/%0d fails=%0d want 1/1/0", pass_count, total_count, fa_q.size()); end
  endtask

  task automatic test_mixed_full_range();
    int mid;
    max_addr = 11'h7FF;
    fill();
    mid = $urandom_range(1, DEPTH - 2);
    mem[0] = ~rom[0]; mem[mid] = rom[mid] ^ 32'h1; mem[DEPTH-1] = rom[DEPTH-1] + 32'd1;
    do_reset();
    feed(2, 200);
    total++; if (obs_done_at !== 14) begin bad++; $display("FAIL mixed_done_time: got %0d want 14", obs_done_at); end
    total++; if (end_reason !== 1'b0 || cycle_count !== 32'd7) begin
      bad++; $display("FAIL mixed_end: got reason=%b cyc=%0d want 0/7", end_reason, cycle_count); end
    collect(DEPTH + 20);
    total++; if (lat !== DEPTH + 1) begin bad++; $display("FAIL full_report_lat: got %0d want %0d", lat, DEPTH + 1); end
    total++; if (total_count !== 12'd2048 || pass_count !== 12'd2045) begin
      bad++; $display("FAIL full_counts: got %0d/%0d want 2045/2048", pass_count, total_count); end
    total++; if (fa_q.size() !== 3) begin bad++; $display("FAIL full_fail_cnt: got %0d want 3", fa_q.size()); end
    else begin
      total++; if (fa_q[0] !== 11'd0 || fa_q[1] !== 11'(mid) || fa_q[2] !== 11'h7FF || fx_q[2] !== mem[DEPTH-1]) begin
        bad++; $display("FAIL full_fail_addrs: got %0h %0h %0h want 0 %0h 7ff", fa_q[0], fa_q[1], fa_q[2], mid); end
    end
    total++; if (con_addr !== 11'h7FF) begin bad++; $display("FAIL full_no_wrap: got %0h want 7ff", con_addr); end
  endtask

  task automatic test_reset_mid_scan();
    int k;
    max_addr = 11'd20;
    fill();
    mem[7] = ~rom[7];
    do_reset();
    feed(0, 200);
    k = 0;
    while (con_addr !== 11'd5 && k < 50) begin @(posedge CLK); #1; k++; end
    total++; if (con_addr !== 11'd5) begin bad++; $display("FAIL midscan_reach: got %0h want 5", con_addr); end
    nrst = 1'b0;
    @(posedge CLK); #1;
    nrst = 1'b1;
    model_clear();
    total++; if (done !== 1'b0 || report_valid !== 1'b0 || con_addr !== '0 || cycle_count !== '0) begin
      bad++; $display("FAIL midscan_reset: got done=%b rep=%b addr=%0h cyc=%0d want 0", done, report_valid, con_addr, cycle_count); end
    total++; if (pass_count !== '0 || total_count !== '0 || fail_valid !== 1'b0 || end_reason !== 1'b0) begin
      bad++; $display("FAIL midscan_reset_cnt: got %0d/%0d fv=%b er=%b want 0", pass_count, total_count, fail_valid, end_reason); end
    feed(0, 200);
    total++; if (obs_done_at !== 29 || cycle_count !== 32'd22) begin
      bad++; $display("FAIL rerun_end: got t=%0d cyc=%0d want 29/22", obs_done_at, cycle_count); end
    collect(60);
    total++; if (lat !== 22 || total_count !== 12'd21 || pass_count !== 12'd20) begin
      bad++; $display("FAIL rerun_counts: got lat=%0d %0d/%0d want 22 20/21", lat, pass_count, total_count); end
    total++; if (fa_q.size() !== 1 || fa_q[0] !== 11'd7) begin
      bad++; $display("FAIL rerun_fail: got n=%0d want one at 7", fa_q.size()); end
  endtask

  task automatic test_random();
    int mx, exp_pass;
    logic [ADDR_W-1:0] ea[$];
    logic [31:0]       ex[$], ee[$];
    for (int it = 0; it < 6; it++) begin
      mx = $urandom_range(0, 40);
      max_addr = 11'(mx);
      fill();
      ea.delete(); ex.delete(); ee.delete(); exp_pass = 0;
      for (int a = 0; a <= mx; a++) begin
        if ($urandom_range(0, 3) == 0) mem[a] = ~rom[a];
        if (mem[a] == rom[a]) exp_pass++;
        else begin ea.push_back(11'(a)); ex.push_back(mem[a]); ee.push_back(rom[a]); end
      end
      do_reset();
      feed(3, 1000);
      total++; if (obs_done_at < 0 || obs_done_at !== m_done_at) begin
        bad++; $display("FAIL rnd%0d_done_time: got %0d want %0d", it, obs_done_at, m_done_at); end
      total++; if (end_reason !== m_reason || cycle_count !== 32'(m_cc)) begin
        bad++; $display("FAIL rnd%0d_end: got %b/%0d want %b/%0d", it, end_reason, cycle_count, m_reason, m_cc); end
      collect(mx + 10);
      total++; if (lat !== mx + 2 || total_count !== 12'(mx + 1) || pass_count !== 12'(exp_pass)) begin
        bad++; $display("FAIL rnd%0d_counts: got lat=%0d %0d/%0d want %0d %0d/%0d",
                        it, lat, pass_count, total_count, mx + 2, exp_pass, mx + 1); end
      total++; if (fa_q.size() !== ea.size()) begin
        bad++; $display("FAIL rnd%0d_fail_cnt: got %0d want %0d", it, fa_q.size(), ea.size()); end
      else begin
        for (int j = 0; j < ea.size(); j++) begin
          total++; if (fa_q[j] !== ea[j] || fx_q[j] !== ex[j] || fe_q[j] !== ee[j]) begin
            bad++; $display("FAIL rnd%0d_fail%0d: got %0h %0h %0h want %0h %0h %0h",
                            it, j, fa_q[j], fx_q[j], fe_q[j], ea[j], ex[j], ee[j]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_end();
    test_loop_end();
    test_mixed_full_range();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
